// File: rtl/key_press_gen.sv
// Emulated active-low push-button: press bounce, clean hold, release bounce, clean settle on the selected key.
// Latency: start sampled at edge T gives busy=1 at T+1; done pulses for one cycle after SETTLE.
// Backpressure: start while busy is dropped. KEY_PRESS_GEN_STATS_EN adds a completed-press counter (press_cnt).
module key_press_gen #(
  parameter int unsigned BOUNCE_CNT = 50,
  parameter int unsigned GAP_MASK   = 63,
  parameter int unsigned HOLD_CYC   = 500,
  parameter int unsigned SETTLE_CYC = 500,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic       clk_50mhz,
  input  logic       rst_n,
  input  logic       start,
  input  logic       sel,
  output logic       key_plus,
  output logic       key_minus,
  output logic       busy,
`ifdef KEY_PRESS_GEN_STATS_EN
  output logic       done,
  output logic [7:0] press_cnt
`else
  output logic       done
`endif
);

  typedef enum logic [2:0] {IDLE, PRESS_BNC, HOLD, REL_BNC, SETTLE} state_t;

  state_t      state_q, state_d;
  logic [15:0] lfsr_q, lfsr_d;
  logic [15:0] bnc_q, bnc_d;
  logic [16:0] gap_q, gap_d, gap_load;
  logic [31:0] tmr_q, tmr_d;
  logic        sel_q, sel_d;
  logic        key_q, key_d;
  logic        busy_d, done_d;

  // Galois form of x^16+x^14+x^13+x^11+1; 17-bit gap so GAP_MASK=16'hFFFF cannot wrap to 0.
  assign lfsr_d   = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
  assign gap_load = {1'b0, lfsr_q & GAP_MASK[15:0]} + 17'd1;

  always_comb begin
    state_d = state_q;
    bnc_d   = bnc_q;
    gap_d   = gap_q;
    tmr_d   = tmr_q;
    sel_d   = sel_q;
    key_d   = key_q;
    busy_d  = busy;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          sel_d  = sel;
          busy_d = 1'b1;
          if (BOUNCE_CNT != 0) begin
            state_d = PRESS_BNC;
            bnc_d   = BOUNCE_CNT[15:0];
            gap_d   = gap_load;
            key_d   = 1'b1;
          end else begin
            state_d = HOLD;
            key_d   = 1'b0;
            tmr_d   = HOLD_CYC;
          end
        end
      end
      PRESS_BNC, REL_BNC: begin
        if (gap_q <= 17'd1) begin
          if (bnc_q <= 16'd1) begin
            // Final expiry lands on the clean level regardless of toggle parity.
            bnc_d = 16'd0;
            if (state_q == PRESS_BNC) begin
              state_d = HOLD;
              key_d   = 1'b0;
              tmr_d   = HOLD_CYC;
            end else begin
              state_d = SETTLE;
              key_d   = 1'b1;
              tmr_d   = SETTLE_CYC;
            end
          end else begin
            key_d = ~key_q;
            bnc_d = bnc_q - 16'd1;
            gap_d = gap_load;
          end
        end else begin
          gap_d = gap_q - 17'd1;
        end
      end
      HOLD: begin
        if (tmr_q <= 32'd1) begin
          if (BOUNCE_CNT != 0) begin
            state_d = REL_BNC;
            bnc_d   = BOUNCE_CNT[15:0];
            gap_d   = gap_load;
          end else begin
            state_d = SETTLE;
            key_d   = 1'b1;
            tmr_d   = SETTLE_CYC;
          end
        end else begin
          tmr_d = tmr_q - 32'd1;
        end
      end
      SETTLE: begin
        if (tmr_q <= 32'd1) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          tmr_d = tmr_q - 32'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_50mhz) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      lfsr_q    <= LFSR_SEED;
      bnc_q     <= 16'd0;
      gap_q     <= 17'd0;
      tmr_q     <= 32'd0;
      sel_q     <= 1'b0;
      key_q     <= 1'b1;
      key_plus  <= 1'b1;
      key_minus <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state_q   <= state_d;
      lfsr_q    <= lfsr_d;
      bnc_q     <= bnc_d;
      gap_q     <= gap_d;
      tmr_q     <= tmr_d;
      sel_q     <= sel_d;
      key_q     <= key_d;
      key_plus  <= sel_d | key_d;
      key_minus <= ~sel_d | key_d;
      busy      <= busy_d;
      done      <= done_d;
    end
  end

`ifdef KEY_PRESS_GEN_STATS_EN
  always_ff @(posedge clk_50mhz) begin
    if (!rst_n) begin
      press_cnt <= 8'd0;
    end else if (done_d) begin
      press_cnt <= press_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_key_press_gen.sv
// Bench for key_press_gen: two instances (clean edges / short bounces) against a schedule-based reference model.
`timescale 1ns/1ps
module tb_key_press_gen;

  localparam int H0 = 10, S0 = 5;
  localparam int N1 = 4, M1 = 3, H1 = 12, S1 = 8;
  localparam logic [15:0] SEED = 16'hACE1;

  logic clk_50mhz = 1'b0;
  always #10 clk_50mhz = ~clk_50mhz;

  logic rst_n, start, sel;
  logic kp0, km0, busy0, done0, kp1, km1, busy1, done1;
`ifdef KEY_PRESS_GEN_STATS_EN
  logic [7:0] pc0, pc1;
`endif

  key_press_gen #(.BOUNCE_CNT(0), .GAP_MASK(63), .HOLD_CYC(H0), .SETTLE_CYC(S0), .LFSR_SEED(SEED)) dut0 (
    .clk_50mhz(clk_50mhz), .rst_n(rst_n), .start(start), .sel(sel),
    .key_plus(kp0), .key_minus(km0), .busy(busy0),
`ifdef KEY_PRESS_GEN_STATS_EN
    .done(done0), .press_cnt(pc0)
`else
    .done(done0)
`endif
  );

  key_press_gen #(.BOUNCE_CNT(N1), .GAP_MASK(M1), .HOLD_CYC(H1), .SETTLE_CYC(S1), .LFSR_SEED(SEED)) dut1 (
    .clk_50mhz(clk_50mhz), .rst_n(rst_n), .start(start), .sel(sel),
    .key_plus(kp1), .key_minus(km1), .busy(busy1),
`ifdef KEY_PRESS_GEN_STATS_EN
    .done(done1), .press_cnt(pc1)
`else
    .done(done1)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;

  function automatic void chk(string nm, logic [7:0] act, logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
    end
  endfunction

  // ---------------- reference model: whole-press schedule computed at accept time ----------------
  typedef struct packed {
    logic       kp;
    logic       km;
    logic       busy;
    logic       done;
    logic [2:0] ph;   // 0 idle, 1 press bounce, 2 hold, 3 release bounce, 4 settle
  } exp_t;

  localparam exp_t IDLE_E = '{kp: 1'b1, km: 1'b1, busy: 1'b0, done: 1'b0, ph: 3'd0};

  exp_t        sched [2][512];
  int          slen [2];
  int          spos [2];
  exp_t        cur [2];
  logic [15:0] lfsr_m;
  logic [7:0]  cnt_m [2];
  bit          model_ok = 0;

  function automatic logic [15:0] lstep(logic [15:0] v);
    return (v >> 1) ^ (v[0] ? 16'hB400 : 16'h0000);
  endfunction

  function automatic exp_t mk(logic key, logic s, logic [2:0] ph, logic b, logic d);
    exp_t e;
    e.kp = s ? 1'b1 : key;
    e.km = s ? key : 1'b1;
    e.busy = b;
    e.done = d;
    e.ph = ph;
    return e;
  endfunction

  // One entry per cycle after the accepting edge; l tracks the LFSR value at each later edge.
  task automatic build(input int i, input int nb, input int mask, input int hold, input int settle,
                       input logic [15:0] l0, input logic s);
    logic [15:0] l;
    logic [15:0] m16;
    logic        key;
    int          n;
    int          g;
    l = l0; m16 = mask[15:0]; key = 1'b1; n = 0;
    for (int b = 1; b <= nb; b++) begin
      g = 1 + int'(l & m16);
      for (int k = 0; k < g; k++) begin sched[i][n] = mk(key, s, 3'd1, 1'b1, 1'b0); n++; l = lstep(l); end
      key = (b == nb) ? 1'b0 : ~key;
    end
    key = 1'b0;
    for (int k = 0; k < ((hold < 1) ? 1 : hold); k++) begin
      sched[i][n] = mk(key, s, 3'd2, 1'b1, 1'b0); n++; l = lstep(l);
    end
    for (int b = 1; b <= nb; b++) begin
      g = 1 + int'(l & m16);
      for (int k = 0; k < g; k++) begin sched[i][n] = mk(key, s, 3'd3, 1'b1, 1'b0); n++; l = lstep(l); end
      key = (b == nb) ? 1'b1 : ~key;
    end
    key = 1'b1;
    for (int k = 0; k < ((settle < 1) ? 1 : settle); k++) begin
      sched[i][n] = mk(key, s, 3'd4, 1'b1, 1'b0); n++; l = lstep(l);
    end
    sched[i][n] = mk(1'b1, s, 3'd0, 1'b0, 1'b1); n++;
    slen[i] = n;
    spos[i] = 0;
  endtask

  initial begin
    slen[0] = 0; slen[1] = 0; spos[0] = 0; spos[1] = 0;
    cur[0] = IDLE_E; cur[1] = IDLE_E;
    cnt_m[0] = 8'd0; cnt_m[1] = 8'd0;
    lfsr_m = SEED;
    forever begin
      @(posedge clk_50mhz);
      if (!rst_n) begin
        lfsr_m = SEED;
        for (int i = 0; i < 2; i++) begin
          slen[i] = 0; spos[i] = 0; cur[i] = IDLE_E; cnt_m[i] = 8'd0;
        end
        model_ok = 1;
      end else begin
        for (int i = 0; i < 2; i++) begin
          if (spos[i] >= slen[i] && start) begin
            if (i == 0) build(0, 0, 63, H0, S0, lfsr_m, sel);
            else        build(1, N1, M1, H1, S1, lfsr_m, sel);
          end
          if (spos[i] < slen[i]) begin cur[i] = sched[i][spos[i]]; spos[i]++; end
          else cur[i] = IDLE_E;
          if (cur[i].done) cnt_m[i] = cnt_m[i] + 8'd1;
        end
        lfsr_m = lstep(lfsr_m);
      end
    end
  end

  // Continuous comparison on the falling edge, away from the active edge.
  initial begin
    forever begin
      @(negedge clk_50mhz);
      if (model_ok) begin
        chk("dut0_out", {4'b0, kp0, km0, busy0, done0}, {4'b0, cur[0].kp, cur[0].km, cur[0].busy, cur[0].done});
        chk("dut1_out", {4'b0, kp1, km1, busy1, done1}, {4'b0, cur[1].kp, cur[1].km, cur[1].busy, cur[1].done});
`ifdef KEY_PRESS_GEN_STATS_EN
        chk("dut0_press_cnt", pc0, cnt_m[0]);
        chk("dut1_press_cnt", pc1, cnt_m[1]);
`endif
      end
    end
  end

  // ---------------- directed and random stimulus ----------------
  typedef struct {
    logic start; logic sel;
    logic kp; logic km; logic busy; logic done;
  } vec_t;
  vec_t tbl [20];

  task automatic wait_idle();
    int k;
    k = 0;
    start = 1'b0;
    @(posedge clk_50mhz); #1;
    while ((spos[0] < slen[0] || spos[1] < slen[1]) && k < 3000) begin
      @(posedge clk_50mhz); #1; k++;
    end
    chk("idle_timeout", {7'b0, k < 3000}, 8'd1);
    @(negedge clk_50mhz);
  endtask

  int   dn, rises, km_low, k;
  logic prev;

  initial begin
    rst_n = 1'b0; start = 1'b0; sel = 1'b0;
    for (int c = 0; c < 20; c++) begin
      tbl[c].start = (c == 0);
      tbl[c].sel   = 1'b0;
      tbl[c].kp    = !(c <= 9);
      tbl[c].km    = 1'b1;
      tbl[c].busy  = (c <= 14);
      tbl[c].done  = (c == 15);
    end
    repeat (3) @(negedge clk_50mhz);
    rst_n = 1'b1;

    // Reset mid-stream: a press is running when rst_n drops for 10 cycles.
    start = 1'b1; sel = 1'b1;
    @(negedge clk_50mhz); start = 1'b0;
    repeat (20) @(negedge clk_50mhz);
    rst_n = 1'b0;
    @(posedge clk_50mhz); #1;
    chk("reset_dut0", {4'b0, kp0, km0, busy0, done0}, 8'h0C);
    chk("reset_dut1", {4'b0, kp1, km1, busy1, done1}, 8'h0C);
    repeat (9) @(negedge clk_50mhz);
    rst_n = 1'b1;
    @(negedge clk_50mhz);

    // Clean press on dut0 (entry c: inputs at edge c, outputs in the cycle after it).
    for (int c = 0; c < 20; c++) begin
      @(negedge clk_50mhz);
      start = tbl[c].start; sel = tbl[c].sel;
      @(posedge clk_50mhz); #1;
      chk("clean_tbl", {4'b0, kp0, km0, busy0, done0},
          {4'b0, tbl[c].kp, tbl[c].km, tbl[c].busy, tbl[c].done});
    end
    wait_idle();

    // Busy lockout: second start (with sel=1) mid-HOLD is ignored.
    dn = 0; rises = 0; km_low = 0; prev = kp0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk_50mhz);
      start = (c == 0 || c == 5); sel = (c == 5);
      @(posedge clk_50mhz); #1;
      if (done0) dn++;
      if (kp0 && !prev) rises++;
      if (!km0) km_low++;
      prev = kp0;
    end
    chk("lockout_done", dn[7:0], 8'd1);
    chk("lockout_rise", rises[7:0], 8'd1);
    chk("lockout_km", km_low[7:0], 8'd0);
    wait_idle();

    // Abort during release bounce on dut1, then a clean rerun from the reset seed.
    @(negedge clk_50mhz); start = 1'b1; sel = 1'b1;
    @(negedge clk_50mhz); start = 1'b0; sel = 1'b0;
    k = 0;
    while (cur[1].ph != 3'd3 && k < 500) begin @(posedge clk_50mhz); #1; k++; end
    chk("abort_reach_rel", {7'b0, k < 500}, 8'd1);
    @(negedge clk_50mhz); rst_n = 1'b0;
    @(posedge clk_50mhz); #1;
    chk("abort_dut1", {4'b0, kp1, km1, busy1, done1}, 8'h0C);
    @(negedge clk_50mhz); rst_n = 1'b1;
    repeat (3) @(negedge clk_50mhz);
    start = 1'b1; sel = 1'b1;
    @(negedge clk_50mhz); start = 1'b0;
    wait_idle();

    // Random starts, selects and occasional resets.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk_50mhz);
      start = ($urandom_range(0, 9) == 0);
      sel   = $urandom_range(0, 1);
      rst_n = ($urandom_range(0, 299) != 0);
    end
    rst_n = 1'b1;
    wait_idle();

`ifdef KEY_PRESS_GEN_STATS_EN
    // 257 back-to-back presses on dut0: start held high so it is accepted on every done cycle.
    rst_n = 1'b0;
    @(negedge clk_50mhz); rst_n = 1'b1; sel = 1'b0; start = 1'b1;
    dn = 0; k = 0;
    while (dn < 257 && k < 8000) begin
      @(posedge clk_50mhz); #1; k++;
      if (done0) begin
        dn++;
        if (dn == 257) chk("stats_257", pc0, 8'd1);
      end
    end
    chk("stats_timeout", {7'b0, k < 8000}, 8'd1);
    @(negedge clk_50mhz);
    wait_idle();
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
